noc_link_stage: RTL and testbench

Registered pipeline stage inserted on the NoC ring between the bus output of one network interface unit and the bus input of the next. It buffers up to DEPTH phits (≤32 bytes each) in a small FIFO and drives every downstream signal and the upstream bus-open from flops. This breaks the combinational bus-open → pop path between neighbouring NIUs so that long ring hops close timing on fclk. It also keeps saturating link statistics and flags malformed phits.

---
 rtl/noc_link_stage.sv | 139 +++++++++++++
 tb/tb_noc_link_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_link_stage.sv
// Registered NoC ring link stage: a DEPTH-entry phit FIFO with every downstream
// output and the upstream bus-open driven from flops, plus saturating link statistics.
module noc_link_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             fclk,
    input  logic             rst,
    input  logic [31:0][7:0] inp_dat,
    input  logic [5:0]       inp_bp,
    output logic             inp_bo,
    output logic [31:0][7:0] oup_dat,
    output logic [5:0]       oup_bp,
    input  logic             oup_bo,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] phit_cnt,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_bp
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("noc_link_stage: DEPTH must be at least 2");
    end

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int SW = ((CNT_W > 6) ? CNT_W : 6) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [31:0][7:0] dat;
        logic [5:0]       bp;
    } phit_t;

    phit_t         mem [DEPTH];
    phit_t         in_phit;
    phit_t         head_nxt;
    phit_t         head_q;
    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt;
    logic [OW-1:0] occ, occ_nxt;
    logic          bp_bad;
    logic          push;
    logic          pop;
    logic [SW-1:0] byte_sum;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Bytes beyond inp_bp are zeroed on entry so the output never leaks stale data.
    always_comb begin
        in_phit    = '0;
        in_phit.bp = inp_bp;
        for (int i = 0; i < 32; i++) begin
            in_phit.dat[i] = (i < int'(inp_bp)) ? inp_dat[i] : 8'h00;
        end
    end

    assign bp_bad = (inp_bp > 6'd32);
    assign push   = inp_bo && (inp_bp != 6'd0) && !bp_bad;
    assign pop    = (oup_bp != 6'd0) && oup_bo;

    always_comb begin
        occ_nxt    = occ;
        wr_ptr_nxt = push ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_nxt = pop  ? ptr_inc(rd_ptr) : rd_ptr;
        case ({push, pop})
            2'b10:   occ_nxt = occ + OW'(1);
            2'b01:   occ_nxt = occ - OW'(1);
            default: occ_nxt = occ;
        endcase
        // The entry being written this cycle becomes the head when it lands at the new read pointer.
        if (occ_nxt == '0) begin
            head_nxt = '0;
        end else if (push && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = in_phit;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // NOTE: the phit array has no reset; occupancy and the head register define validity,
    // so clearing storage would only add reset fan-out.
    always_ff @(posedge fclk) begin
        if (push) begin
            mem[wr_ptr] <= in_phit;
        end
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            head_q <= '0;
            inp_bo <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            occ    <= occ_nxt;
            head_q <= head_nxt;
            inp_bo <= (occ_nxt < OW'(DEPTH));
        end
    end

    assign oup_dat = head_q.dat;
    assign oup_bp  = head_q.bp;

    assign byte_sum = SW'(byte_cnt) + SW'(oup_bp);

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            phit_cnt  <= '0;
            byte_cnt  <= '0;
            stall_cnt <= '0;
            err_bp    <= 1'b0;
        end else if (clr_stats) begin
            phit_cnt  <= '0;
            byte_cnt  <= '0;
            stall_cnt <= '0;
            err_bp    <= 1'b0;
        end else begin
            if (pop) begin
                phit_cnt <= (phit_cnt == CNT_MAX) ? phit_cnt : phit_cnt + CNT_W'(1);
                byte_cnt <= (byte_sum > SW'(CNT_MAX)) ? CNT_MAX : byte_sum[CNT_W-1:0];
            end
            if ((oup_bp != 6'd0) && !oup_bo && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (inp_bo && bp_bad) begin
                err_bp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_link_stage.sv
// Directed bench for noc_link_stage: a driver queues expected phits on acceptance and a
// monitor compares them against every downstream transfer.
module tb_noc_link_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [5:0]       bp;
        logic [31:0][7:0] dat;
    } exp_t;

    logic             fclk;
    logic             rst;
    logic [31:0][7:0] inp_dat;
    logic [5:0]       inp_bp;
    logic             inp_bo;
    logic [31:0][7:0] oup_dat;
    logic [5:0]       oup_bp;
    logic             oup_bo;
    logic             clr_stats;
    logic [CNT_W-1:0] phit_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             err_bp;

    int   checks = 0;
    int   errors = 0;
    int   outs   = 0;
    int   waits  = 0;
    exp_t sb[$];

    noc_link_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .fclk      (fclk),
        .rst       (rst),
        .inp_dat   (inp_dat),
        .inp_bp    (inp_bp),
        .inp_bo    (inp_bo),
        .oup_dat   (oup_dat),
        .oup_bp    (oup_bp),
        .oup_bo    (oup_bo),
        .clr_stats (clr_stats),
        .phit_cnt  (phit_cnt),
        .byte_cnt  (byte_cnt),
        .stall_cnt (stall_cnt),
        .err_bp    (err_bp)
    );

    initial begin
        fclk = 1'b0;
        forever #5 fclk = ~fclk;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0][7:0] ramp(input logic [7:0] s);
        logic [31:0][7:0] r;
        for (int i = 0; i < 32; i++) r[i] = s + 8'(i);
        return r;
    endfunction

    function automatic exp_t expect_of(input logic [5:0] bp, input logic [31:0][7:0] d);
        exp_t e;
        e.bp = bp;
        for (int i = 0; i < 32; i++) e.dat[i] = (i < int'(bp)) ? d[i] : 8'h00;
        return e;
    endfunction

    task automatic tick();
        @(negedge fclk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [5:0] bp, input logic [31:0][7:0] d, input bit track);
        int n = 0;
        inp_bp  = bp;
        inp_dat = d;
        while (!inp_bo && n < 50) begin
            @(negedge fclk);
            n++;
        end
        if (!inp_bo) begin
            check("send_timeout", {255'b0, inp_bo}, 256'd1);
        end else begin
            waits += n;
            if (track) sb.push_back(expect_of(bp, d));
        end
        @(posedge fclk);
        #1;
        inp_bp = 6'd0;
        @(negedge fclk);
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    // Monitor: samples mid-low-phase, after the driver has settled its inputs.
    always begin
        exp_t e;
        @(negedge fclk);
        #2;
        if (!rst && oup_bp != 6'd0 && oup_bo) begin
            outs++;
            if (sb.size() == 0) begin
                check("unexpected_phit", {250'b0, oup_bp}, 256'd0);
            end else begin
                e = sb.pop_front();
                check("out_bp", {250'b0, oup_bp}, {250'b0, e.bp});
                check("out_dat", oup_dat, e.dat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst       = 1'b1;
        inp_dat   = '0;
        inp_bp    = 6'd0;
        oup_bo    = 1'b1;
        clr_stats = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_inp_bo", {255'b0, inp_bo}, 256'd0);
        check("rst_oup_bp", {250'b0, oup_bp}, 256'd0);
        check("rst_oup_dat", oup_dat, 256'd0);
        check("rst_phit_cnt", {248'b0, phit_cnt}, 256'd0);
        check("rst_byte_cnt", {248'b0, byte_cnt}, 256'd0);
        check("rst_stall_cnt", {248'b0, stall_cnt}, 256'd0);
        check("rst_err_bp", {255'b0, err_bp}, 256'd0);
        rst = 1'b0;
        tick();
        check("rel_inp_bo", {255'b0, inp_bo}, 256'd1);
        check("rel_oup_bp", {250'b0, oup_bp}, 256'd0);

        // Single full phit: visible one cycle after acceptance
        send(6'd32, ramp(8'h00), 1'b1);
        check("lat_bp", {250'b0, oup_bp}, 256'd32);
        check("lat_dat", oup_dat, ramp(8'h00));
        tick();
        check("one_phit_cnt", {248'b0, phit_cnt}, 256'd1);
        check("one_byte_cnt", {248'b0, byte_cnt}, 256'd32);
        check("one_empty", {250'b0, oup_bp}, 256'd0);

        // Partial phit with stale upper bytes
        send(6'd5, {32{8'hAA}}, 1'b1);
        check("part_bp", {250'b0, oup_bp}, 256'd5);
        check("part_upper_zero", {40'b0, oup_dat[31:5]}, 256'd0);
        tick();
        check("part_byte_cnt", {248'b0, byte_cnt}, 256'd37);

        // Ten back-to-back phits, bp 1..10
        pulse_clr();
        waits = 0;
        base  = outs;
        for (int k = 0; k < 10; k++) send(6'(k + 1), ramp(8'(k * 16)), 1'b1);
        tick();
        check("stream_no_bo_drop", 256'(waits), 256'd0);
        check("stream_outs", 256'(outs - base), 256'd10);
        check("stream_phit_cnt", {248'b0, phit_cnt}, 256'd10);
        check("stream_byte_cnt", {248'b0, byte_cnt}, 256'd55);
        check("stream_stall_cnt", {248'b0, stall_cnt}, 256'd0);

        // Backpressure: two absorbed, third held off
        pulse_clr();
        oup_bo = 1'b0;
        send(6'd32, ramp(8'h40), 1'b1);
        send(6'd8, ramp(8'h80), 1'b1);
        check("bp_full_bo", {255'b0, inp_bo}, 256'd0);
        check("bp_stall1", {248'b0, stall_cnt}, 256'd1);
        inp_bp  = 6'd16;
        inp_dat = ramp(8'hC0);
        tick();
        check("bp_still_full", {255'b0, inp_bo}, 256'd0);
        check("bp_stall2", {248'b0, stall_cnt}, 256'd2);
        tick();
        check("bp_stall3", {248'b0, stall_cnt}, 256'd3);
        oup_bo = 1'b1;
        tick();
        check("bp_bo_after_pop", {255'b0, inp_bo}, 256'd1);
        check("bp_stall_hold", {248'b0, stall_cnt}, 256'd3);
        check("bp_phit1", {248'b0, phit_cnt}, 256'd1);
        send(6'd16, ramp(8'hC0), 1'b1);
        send(6'd20, ramp(8'hE0), 1'b1);
        tick();
        check("bp_drained_phits", {248'b0, phit_cnt}, 256'd4);
        check("bp_drained_bytes", {248'b0, byte_cnt}, 256'd76);

        // Illegal bp, then clear colliding with a forward
        pulse_clr();
        inp_bp  = 6'd40;
        inp_dat = ramp(8'h33);
        tick();
        inp_bp = 6'd0;
        check("ill_err_bp", {255'b0, err_bp}, 256'd1);
        check("ill_no_store", {250'b0, oup_bp}, 256'd0);
        check("ill_inp_bo", {255'b0, inp_bo}, 256'd1);
        check("ill_phit_cnt", {248'b0, phit_cnt}, 256'd0);
        check("ill_byte_cnt", {248'b0, byte_cnt}, 256'd0);
        send(6'd12, ramp(8'h10), 1'b1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_err_bp", {255'b0, err_bp}, 256'd0);
        check("clr_phit_cnt", {248'b0, phit_cnt}, 256'd0);
        check("clr_byte_cnt", {248'b0, byte_cnt}, 256'd0);
        check("clr_stall_cnt", {248'b0, stall_cnt}, 256'd0);

        // byte_cnt saturation at 8 bits
        for (int k = 0; k < 8; k++) send(6'd32, ramp(8'(k)), 1'b1);
        tick();
        check("sat_byte_cnt", {248'b0, byte_cnt}, 256'd255);
        check("sat_phit_cnt", {248'b0, phit_cnt}, 256'd8);

        // Reset with two phits buffered: nothing emerges afterwards
        oup_bo = 1'b0;
        send(6'd32, ramp(8'h55), 1'b0);
        send(6'd32, ramp(8'h66), 1'b0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_oup_bp", {250'b0, oup_bp}, 256'd0);
        check("mid_rst_inp_bo", {255'b0, inp_bo}, 256'd0);
        tick();
        rst    = 1'b0;
        oup_bo = 1'b1;
        base   = outs;
        repeat (4) tick();
        check("post_rst_no_out", 256'(outs - base), 256'd0);
        check("post_rst_oup_bp", {250'b0, oup_bp}, 256'd0);
        check("post_rst_inp_bo", {255'b0, inp_bo}, 256'd1);
        check("post_rst_byte_cnt", {248'b0, byte_cnt}, 256'd0);
        check("sb_empty", 256'(sb.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
